result_display_sequencer: RTL and testbench
===========================================

// Module: result_display_sequencer
// PURPOSE
// - Sequences the eight-digit seven-segment display that shows the hands and messages.
// - Sits between the game FSM and the per-digit decoder.
// - In idle it drives a steady message (STRT/DEAL/PLAY). On a result request it blinks the result word, then holds it steady.
// - At the end it returns a one-cycle done pulse, so the game FSM waits on the display rather than on a timer of its own.
// PARAMETERS
// - TICK_DIV     25000000  clk cycles per display phase (0.5 s at 50 MHz); >= 2
// - CNT_W        25        prescaler width; 2**CNT_W >= TICK_DIV
// - BLINK_COUNT  3         number of ON/OFF blink pairs; 0 = no blinking
// - HOLD_TICKS   4         phases the result is held steady after blinking; >= 1
// PORTS
// - clk          in   1  system clock
// - reset        in   1  asynchronous, active-high reset
// - state_msg    in   3  idle message: 0 STRT, 1 DEAL, 2 PLAY, 3-7 PLAY
// - result_req   in   1  request a result sequence (level or pulse)
// - result_code  in   2  0 WIN, 1 LOSE, 2 TIE, 3 BLJK; sampled on accept
// - result_busy  out  1  high while a sequence is in progress (accept+1 through DONE)
// - result_done  out  1  one-cycle pulse at end of sequence
// - blank_hands  out  1  high during blink-OFF phases (see CONFIGURATION)
// - letter3..0   out  6  per-digit character codes for message digits 3..0
// BEHAVIOUR
// - Character codes: digits 0x00-0x09; A-Z = 0x0A-0x23; OFF = 0x3F.
// - Words: STRT, DEAL, PLAY, LOSE, BLJK fill all four digits; WIN and TIE are OFF,W,I,N and OFF,T,I,E.
// - All outputs are registered.
// - Reset values: letters = 0x3F, result_busy = 0, result_done = 0, blank_hands = 0, FSM = IDLE, prescaler = 0, counters = 0.
// - Prescaler: counts 0..TICK_DIV-1 and wraps. tick is asserted while count == TICK_DIV-1. It is forced to 0 on accept.
// - FSM states: IDLE, BLINK_ON, BLINK_OFF, HOLD, DONE.
//   - IDLE: letters <= word(state_msg) each cycle (1-cycle latency). When result_req = 1: latch result_code, clear the prescaler, clear the counters, go to BLINK_ON (BLINK_COUNT > 0) or HOLD (BLINK_COUNT = 0).
//   - BLINK_ON: letters = result word. On tick -> BLINK_OFF.
//   - BLINK_OFF: letters = all OFF, blank_hands = 1. On tick, count the pair; after the BLINK_COUNT-th pair -> HOLD, else -> BLINK_ON.
//   - HOLD: letters = result word. After HOLD_TICKS ticks -> DONE.
//   - DONE: exactly one cycle; result_done = 1, result_busy = 1, letters unchanged. Then -> IDLE; result_busy = 0 from the next cycle.
// - Timing: accept at cycle 0; each phase lasts exactly TICK_DIV cycles; DONE at cycle 1 + (2*BLINK_COUNT + HOLD_TICKS)*TICK_DIV.
// - Boundary conditions:
//   - result_req outside IDLE (including DONE) is ignored; the latched code is not changed.
//   - A level result_req still high in the first IDLE cycle after DONE starts a new sequence.
//   - state_msg changes during a sequence have no effect until IDLE.
//   - reset mid-sequence aborts immediately to reset values; no done pulse.
// CONFIGURATION
// - DISP_BLANK_HANDS_EN defined: blank_hands is high exactly in BLINK_OFF cycles, so the hand digits flash with the message.
// - DISP_BLANK_HANDS_EN undefined: blank_hands is constant 0; letter behaviour is unchanged.
// TESTING (TICK_DIV=4, BLINK_COUNT=2, HOLD_TICKS=3, DISP_BLANK_HANDS_EN defined, unless noted)
// - Reset with state_msg=1, then release -> letters 3F,3F,3F,3F, then one cycle later 0D,0E,0A,15.
// - 1-cycle result_req, code 0, at cycle 0 -> busy from cycle 1.
//   - Cycles 1-4: 3F,20,12,17. Cycles 5-8: all 3F, blank_hands=1. Cycles 9-12: on. Cycles 13-16: off.
//   - Cycles 17-28: hold. result_done=1 at cycle 29 only. busy=0 at cycle 30.
// - result_req with code 1 at cycle 6 of the above -> ignored; the word remains WIN throughout.
// - reset pulsed at cycle 10 mid-sequence -> letters 3F, busy 0, blank_hands 0 at once; no done pulse; IDLE message after release.
// - BLINK_COUNT=0 instance, request code 3 -> letters 0B,15,13,14 steady from cycle 1; done at cycle 13; blank_hands never 1.
// - result_req held high, code 2 -> first done at cycle 29, re-accept at cycle 30, busy again at 31, second done at cycle 59.
// - Build without DISP_BLANK_HANDS_EN, repeat the second scenario -> identical letters, blank_hands constant 0.

Source files
------------

// File: rtl/result_display_sequencer.sv
// Drives the four message digits: an idle word, or a blinking-then-steady result word ending in a done pulse.
// Build option: define DISP_BLANK_HANDS_EN so that blank_hands follows the blink-OFF phases.
module result_display_sequencer #(
  parameter int TICK_DIV    = 25000000,
  parameter int CNT_W       = 25,
  parameter int BLINK_COUNT = 3,
  parameter int HOLD_TICKS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state_msg,
  input  logic       result_req,
  input  logic [1:0] result_code,
  output logic       result_busy,
  output logic       result_done,
  output logic       blank_hands,
  output logic [5:0] letter3,
  output logic [5:0] letter2,
  output logic [5:0] letter1,
  output logic [5:0] letter0,
  output logic [2:0] dbgState
);

  localparam int PAIR_W = (BLINK_COUNT < 2) ? 1 : $clog2(BLINK_COUNT + 1);
  localparam int HOLD_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] PRESC_TOP = CNT_W'(TICK_DIV - 1);
  localparam logic [23:0] ALL_OFF = {4{6'h3F}};

  typedef enum logic [2:0] {IDLE, BLINK_ON, BLINK_OFF, HOLD, DONE} dispState_e;

  dispState_e        stateQ, stateNext;
  logic [1:0]        codeQ, codeNext;
  logic [PAIR_W-1:0] pairCnt, pairNext;
  logic [HOLD_W-1:0] holdCnt, holdNext;
  logic [CNT_W-1:0]  prescQ;
  logic              clearPresc;
  logic              tick;
  logic [23:0]       lettersQ, lettersNext;

  function automatic logic [23:0] msgWord(input logic [2:0] msg);
    case (msg)
      3'd0:    msgWord = {6'h1C, 6'h1D, 6'h1B, 6'h1D};  // STRT
      3'd1:    msgWord = {6'h0D, 6'h0E, 6'h0A, 6'h15};  // DEAL
      default: msgWord = {6'h19, 6'h15, 6'h0A, 6'h22};  // PLAY
    endcase
  endfunction

  function automatic logic [23:0] resultWord(input logic [1:0] code);
    case (code)
      2'd0:    resultWord = {6'h3F, 6'h20, 6'h12, 6'h17};  // _WIN
      2'd1:    resultWord = {6'h15, 6'h18, 6'h1C, 6'h0E};  // LOSE
      2'd2:    resultWord = {6'h3F, 6'h1D, 6'h12, 6'h0E};  // _TIE
      default: resultWord = {6'h0B, 6'h15, 6'h13, 6'h14};  // BLJK
    endcase
  endfunction

  // The phase tick only matters inside a sequence; the prescaler restarts on accept.
  assign tick = (stateQ != IDLE) && (prescQ == PRESC_TOP);

  always_comb begin
    stateNext  = stateQ;
    codeNext   = codeQ;
    pairNext   = pairCnt;
    holdNext   = holdCnt;
    clearPresc = 1'b0;
    case (stateQ)
      IDLE: begin
        if (result_req) begin
          codeNext   = result_code;
          clearPresc = 1'b1;
          pairNext   = '0;
          holdNext   = '0;
          stateNext  = (BLINK_COUNT > 0) ? BLINK_ON : HOLD;
        end
      end
      BLINK_ON: if (tick) stateNext = BLINK_OFF;
      BLINK_OFF: begin
        if (tick) begin
          if (int'(pairCnt) >= BLINK_COUNT - 1) begin
            pairNext  = '0;
            stateNext = HOLD;
          end else begin
            pairNext  = pairCnt + 1'b1;
            stateNext = BLINK_ON;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (int'(holdCnt) >= HOLD_TICKS - 1) stateNext = DONE;
          else holdNext = holdCnt + 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered letters line up with the phase.
  always_comb begin
    lettersNext = lettersQ;
    case (stateNext)
      IDLE:           lettersNext = msgWord(state_msg);
      BLINK_OFF:      lettersNext = ALL_OFF;
      BLINK_ON, HOLD: lettersNext = resultWord(codeNext);
      default:        lettersNext = lettersQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ      <= IDLE;
      codeQ       <= 2'd0;
      pairCnt     <= '0;
      holdCnt     <= '0;
      prescQ      <= '0;
      lettersQ    <= ALL_OFF;
      result_busy <= 1'b0;
      result_done <= 1'b0;
    end else begin
      stateQ      <= stateNext;
      codeQ       <= codeNext;
      pairCnt     <= pairNext;
      holdCnt     <= holdNext;
      if (clearPresc || prescQ == PRESC_TOP) prescQ <= '0;
      else prescQ <= prescQ + 1'b1;
      lettersQ    <= lettersNext;
      result_busy <= (stateNext != IDLE);
      result_done <= (stateNext == DONE);
    end
  end

`ifdef DISP_BLANK_HANDS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) blank_hands <= 1'b0;
    else blank_hands <= (stateNext == BLINK_OFF);
  end
`else
  assign blank_hands = 1'b0;
`endif

  assign {letter3, letter2, letter1, letter0} = lettersQ;
  assign dbgState = stateQ;

endmodule

// File: tb/tb_result_display_sequencer.sv
// Directed bench for result_display_sequencer: idle messages, blink/hold timing, ignored requests, reset abort, no-blink instance.
module tb_result_display_sequencer;

`ifdef DISP_BLANK_HANDS_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [23:0] W_OFF  = {4{6'h3F}};
  localparam logic [23:0] W_STRT = {6'h1C, 6'h1D, 6'h1B, 6'h1D};
  localparam logic [23:0] W_DEAL = {6'h0D, 6'h0E, 6'h0A, 6'h15};
  localparam logic [23:0] W_PLAY = {6'h19, 6'h15, 6'h0A, 6'h22};
  localparam logic [23:0] W_WIN  = {6'h3F, 6'h20, 6'h12, 6'h17};
  localparam logic [23:0] W_TIE  = {6'h3F, 6'h1D, 6'h12, 6'h0E};
  localparam logic [23:0] W_BLJK = {6'h0B, 6'h15, 6'h13, 6'h14};

  logic       clk;
  logic       reset;
  logic [2:0] state_msg;
  logic       req_a, req_b;
  logic [1:0] code_a, code_b;
  logic       busy_a, done_a, blank_a;
  logic       busy_b, done_b, blank_b;
  logic [5:0] l3_a, l2_a, l1_a, l0_a;
  logic [5:0] l3_b, l2_b, l1_b, l0_b;
  logic [2:0] dbg_a, dbg_b;

  int tests = 0;
  int fails = 0;

  result_display_sequencer #(.TICK_DIV(4), .CNT_W(3), .BLINK_COUNT(2), .HOLD_TICKS(3)) dut (
    .clk(clk), .reset(reset), .state_msg(state_msg), .result_req(req_a), .result_code(code_a),
    .result_busy(busy_a), .result_done(done_a), .blank_hands(blank_a),
    .letter3(l3_a), .letter2(l2_a), .letter1(l1_a), .letter0(l0_a), .dbgState(dbg_a)
  );

  result_display_sequencer #(.TICK_DIV(4), .CNT_W(3), .BLINK_COUNT(0), .HOLD_TICKS(3)) dut0 (
    .clk(clk), .reset(reset), .state_msg(state_msg), .result_req(req_b), .result_code(code_b),
    .result_busy(busy_b), .result_done(done_b), .blank_hands(blank_b),
    .letter3(l3_b), .letter2(l2_b), .letter1(l1_b), .letter0(l0_b), .dbgState(dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit off_phase(input int k);
    return (k >= 5 && k <= 8) || (k >= 13 && k <= 16);
  endfunction

  initial begin
    reset = 1'b1; state_msg = 3'd1;
    req_a = 1'b0; code_a = 2'd0; req_b = 1'b0; code_b = 2'd0;

    // reset values, then idle message one cycle after release
    #3;
    chk("rst_letters_a", {8'h0, l3_a, l2_a, l1_a, l0_a}, {8'h0, W_OFF});
    chk("rst_letters_b", {8'h0, l3_b, l2_b, l1_b, l0_b}, {8'h0, W_OFF});
    chk("rst_flags_a", {29'h0, busy_a, done_a, blank_a}, 32'h0);
    next_cycle();
    reset = 1'b0;
    chk("rel_letters", {8'h0, l3_a, l2_a, l1_a, l0_a}, {8'h0, W_OFF});
    next_cycle();
    chk("idle_deal", {8'h0, l3_a, l2_a, l1_a, l0_a}, {8'h0, W_DEAL});

    // single-cycle WIN request; a LOSE request at cycle 6 must be ignored
    state_msg = 3'd2;
    next_cycle();
    req_a = 1'b1; code_a = 2'd0;
    next_cycle();
    req_a = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) next_cycle();
      if (c == 6) begin req_a = 1'b1; code_a = 2'd1; end
      if (c == 7) begin req_a = 1'b0; code_a = 2'd0; end
      chk($sformatf("win_letters_c%0d", c), {8'h0, l3_a, l2_a, l1_a, l0_a},
          {8'h0, (c == 30) ? W_PLAY : (off_phase(c) ? W_OFF : W_WIN)});
      chk($sformatf("win_busy_c%0d", c), {31'h0, busy_a}, {31'h0, c <= 29});
      chk($sformatf("win_done_c%0d", c), {31'h0, done_a}, {31'h0, c == 29});
      chk($sformatf("win_blank_c%0d", c), {31'h0, blank_a}, {31'h0, BLANK_EN && off_phase(c)});
    end

    // reset at cycle 10 aborts the sequence at once, with no done pulse afterwards
    next_cycle();
    req_a = 1'b1; code_a = 2'd2;
    next_cycle();
    req_a = 1'b0;
    for (int c = 2; c <= 10; c++) next_cycle();
    reset = 1'b1;
    #1;
    chk("abort_letters", {8'h0, l3_a, l2_a, l1_a, l0_a}, {8'h0, W_OFF});
    chk("abort_flags", {29'h0, busy_a, done_a, blank_a}, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      next_cycle();
      if (c == 1) chk("abort_idle_msg", {8'h0, l3_a, l2_a, l1_a, l0_a}, {8'h0, W_PLAY});
      chk($sformatf("abort_nodone_c%0d", c), {30'h0, busy_a, done_a}, 32'h0);
    end

    // no-blink instance: BLJK steady from cycle 1, done at cycle 13
    req_b = 1'b1; code_b = 2'd3;
    next_cycle();
    req_b = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) next_cycle();
      chk($sformatf("bljk_letters_c%0d", c), {8'h0, l3_b, l2_b, l1_b, l0_b},
          {8'h0, (c == 14) ? W_PLAY : W_BLJK});
      chk($sformatf("bljk_busy_c%0d", c), {31'h0, busy_b}, {31'h0, c <= 13});
      chk($sformatf("bljk_done_c%0d", c), {31'h0, done_b}, {31'h0, c == 13});
      chk($sformatf("bljk_blank_c%0d", c), {31'h0, blank_b}, 32'h0);
    end

    // level request with TIE: back-to-back sequences; state_msg change shows only in IDLE
    state_msg = 3'd1;
    next_cycle();
    req_a = 1'b1; code_a = 2'd2;
    for (int c = 1; c <= 60; c++) begin
      int k;
      next_cycle();
      if (c == 5) state_msg = 3'd0;
      k = (c > 30) ? c - 30 : c;
      if (k == 30) begin
        chk($sformatf("lvl_idle_letters_c%0d", c), {8'h0, l3_a, l2_a, l1_a, l0_a}, {8'h0, W_STRT});
        chk($sformatf("lvl_idle_flags_c%0d", c), {29'h0, busy_a, done_a, blank_a}, 32'h0);
      end else begin
        chk($sformatf("lvl_letters_c%0d", c), {8'h0, l3_a, l2_a, l1_a, l0_a},
            {8'h0, off_phase(k) ? W_OFF : W_TIE});
        chk($sformatf("lvl_busy_c%0d", c), {31'h0, busy_a}, 32'h1);
        chk($sformatf("lvl_done_c%0d", c), {31'h0, done_a}, {31'h0, k == 29});
        chk($sformatf("lvl_blank_c%0d", c), {31'h0, blank_a}, {31'h0, BLANK_EN && off_phase(k)});
      end
      if (c == 59) req_a = 1'b0;
    end
    next_cycle();
    chk("lvl_stays_idle", {31'h0, busy_a}, 32'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
